// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for the radix-2 Booth multiplier datapath.
// Loads the operands, runs N_LEN evaluate/shift iterations driven by the
// datapath's {Q0, Q-1} bit pair, then raises Done/Valid for one cycle.
// Optional feature macro: BOOTH_CTRL_OVR_EN adds a sticky Overrun flag that
// records a Start request made while an operation was still in progress.

module booth_ctrl #(
  parameter int N_LEN = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Q_in,
  output logic       Busy,
  output logic       Valid,
  output logic       Request,
  output logic       Done,
  output logic       add_s,
  output logic       sub_s,
  output logic       ashift_s
`ifdef BOOTH_CTRL_OVR_EN
  ,
  output logic       Overrun
`endif
);

  localparam int CNT_W = $clog2(N_LEN + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EVAL   = 3'd2,
    ADD    = 3'd3,
    SUB    = 3'd4,
    SHIFT  = 3'd5,
    FINISH = 3'd6
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  logic nxt_busy;
  logic nxt_valid;
  logic nxt_request;
  logic nxt_done;
  logic nxt_add;
  logic nxt_sub;
  logic nxt_ashift;

  // Next-state choice; the Booth bit pair only matters when leaving EVAL,
  // and any unused encoding falls back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = Start ? LOAD : IDLE;
      LOAD:    next_state = EVAL;
      EVAL: begin
        case (Q_in)
          2'b01:   next_state = ADD;
          2'b10:   next_state = SUB;
          default: next_state = SHIFT;
        endcase
      end
      ADD:     next_state = SHIFT;
      SUB:     next_state = SHIFT;
      SHIFT:   next_state = (cnt == CNT_W'(1)) ? FINISH : EVAL;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore output decode of the state being entered, so the output flops
  // always mirror the state register one-for-one.
  always_comb begin
    nxt_busy    = 1'b1;
    nxt_valid   = 1'b0;
    nxt_request = 1'b0;
    nxt_done    = 1'b0;
    nxt_add     = 1'b0;
    nxt_sub     = 1'b0;
    nxt_ashift  = 1'b0;
    case (next_state)
      IDLE:    nxt_busy    = 1'b0;
      LOAD:    nxt_request = 1'b1;
      ADD:     nxt_add     = 1'b1;
      SUB:     nxt_sub     = 1'b1;
      SHIFT:   nxt_ashift  = 1'b1;
      FINISH: begin
        nxt_done  = 1'b1;
        nxt_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // State register and registered outputs; reset parks everything in IDLE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Request  <= 1'b0;
      Done     <= 1'b0;
      add_s    <= 1'b0;
      sub_s    <= 1'b0;
      ashift_s <= 1'b0;
    end else begin
      state    <= next_state;
      Busy     <= nxt_busy;
      Valid    <= nxt_valid;
      Request  <= nxt_request;
      Done     <= nxt_done;
      add_s    <= nxt_add;
      sub_s    <= nxt_sub;
      ashift_s <= nxt_ashift;
    end
  end

  // Iteration counter: loaded during LOAD, counts down once per shift.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (state == LOAD) begin
      cnt <= CNT_W'(N_LEN);
    end else if (state == SHIFT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef BOOTH_CTRL_OVR_EN
  // Sticky flag for a Start seen while busy; an accepted Start clears it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Overrun <= 1'b0;
    end else if (Start && (state == IDLE)) begin
      Overrun <= 1'b0;
    end else if (Start && Busy) begin
      Overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: bench for booth_ctrl (N_LEN = 8). A behavioural Booth
// datapath feeds Q_in back to the controller; expected strobe timelines are
// built from the Booth bit pairs and products are checked against plain
// signed multiplication. Build with BOOTH_CTRL_OVR_EN to cover Overrun.

module tb_booth_ctrl;

  localparam int N_LEN = 8;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] Q_in;
  logic       Busy;
  logic       Valid;
  logic       Request;
  logic       Done;
  logic       add_s;
  logic       sub_s;
  logic       ashift_s;
`ifdef BOOTH_CTRL_OVR_EN
  logic       Overrun;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Datapath model state and the Q_in source selection
  logic signed [8:0] acc;
  logic [7:0]        qreg;
  logic              qm1;
  logic [7:0]        dp_m;
  logic [7:0]        dp_r;
  logic              use_dp;
  logic [1:0]        q_force;

  // Expected per-cycle timeline of the current operation
  bit e_add [64];
  bit e_sub [64];
  bit e_sh  [64];
  int e_lat;

  booth_ctrl #(.N_LEN(N_LEN)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Q_in     (Q_in),
    .Busy     (Busy),
    .Valid    (Valid),
    .Request  (Request),
    .Done     (Done),
    .add_s    (add_s),
    .sub_s    (sub_s),
    .ashift_s (ashift_s)
`ifdef BOOTH_CTRL_OVR_EN
    ,
    .Overrun  (Overrun)
`endif
  );

  always #5 Clock = ~Clock;

  assign Q_in = use_dp ? {qreg[0], qm1} : q_force;

  // Behavioural Booth datapath: 9-bit accumulator so -128 can be subtracted
  always @(posedge Clock) begin
    if (Request) begin
      acc  <= '0;
      qreg <= dp_r;
      qm1  <= 1'b0;
    end else if (add_s) begin
      acc <= acc + {dp_m[7], dp_m};
    end else if (sub_s) begin
      acc <= acc - {dp_m[7], dp_m};
    end else if (ashift_s) begin
      {acc, qreg, qm1} <= {acc[8], acc, qreg};
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"},    Busy,     0);
    check_output({tag, "_valid"},   Valid,    0);
    check_output({tag, "_request"}, Request,  0);
    check_output({tag, "_done"},    Done,     0);
    check_output({tag, "_add"},     add_s,    0);
    check_output({tag, "_sub"},     sub_s,    0);
    check_output({tag, "_ashift"},  ashift_s, 0);
`ifdef BOOTH_CTRL_OVR_EN
    check_output({tag, "_overrun"}, Overrun,  0);
`endif
  endtask

  // Lay out the expected cycles: LOAD in cycle 1, then per Booth pair an
  // EVAL, an optional ADD/SUB, and a SHIFT; FINISH follows the last shift.
  task automatic build_expect(input logic dp, input logic [1:0] qf, input logic [7:0] r);
    int         pos;
    logic       prev;
    logic [1:0] pr;
    for (int i = 0; i < 64; i++) begin
      e_add[i] = 1'b0;
      e_sub[i] = 1'b0;
      e_sh[i]  = 1'b0;
    end
    pos  = 2;
    prev = 1'b0;
    for (int i = 0; i < N_LEN; i++) begin
      pr   = dp ? {r[i], prev} : qf;
      prev = r[i];
      if (pr == 2'b01) begin
        e_add[pos + 1] = 1'b1;
        e_sh[pos + 2]  = 1'b1;
        pos += 3;
      end else if (pr == 2'b10) begin
        e_sub[pos + 1] = 1'b1;
        e_sh[pos + 2]  = 1'b1;
        pos += 3;
      end else begin
        e_sh[pos + 1] = 1'b1;
        pos += 2;
      end
    end
    e_lat = pos;
  endtask

  // One full operation from Start to the IDLE cycle after Valid
  task automatic apply_stimulus(input string tag, input logic dp, input logic [1:0] qf,
                                input logic [7:0] m, input logic [7:0] r, input logic hold);
    int  cyc;
    int  prod;
    bit  seen;
    build_expect(dp, qf, r);
    use_dp  = dp;
    q_force = qf;
    dp_m    = m;
    dp_r    = r;
    Start   = 1'b1;
    tick();
    if (!hold) Start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      check_output({tag, "_request"}, Request,  cyc == 1);
      check_output({tag, "_busy"},    Busy,     1);
      check_output({tag, "_add"},     add_s,    e_add[cyc]);
      check_output({tag, "_sub"},     sub_s,    e_sub[cyc]);
      check_output({tag, "_ashift"},  ashift_s, e_sh[cyc]);
      check_output({tag, "_done"},    Done,     cyc == e_lat);
      check_output({tag, "_valid"},   Valid,    cyc == e_lat);
`ifdef BOOTH_CTRL_OVR_EN
      check_output({tag, "_overrun"}, Overrun,  hold && cyc >= 2);
`endif
      if (Valid) begin
        seen = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check_output({tag, "_latency"}, seen ? cyc : 0, e_lat);
    if (dp && seen) begin
      prod = int'($signed(m)) * int'($signed(r));
      check_output({tag, "_result"}, {16'h0, acc[7:0], qreg}, {16'h0, prod[15:0]});
    end
    tick();
    check_output({tag, "_busy_fall"}, Busy,  0);
    check_output({tag, "_valid_end"}, Valid, 0);
`ifdef BOOTH_CTRL_OVR_EN
    check_output({tag, "_overrun_end"}, Overrun, hold);
`endif
    Start = 1'b0;
  endtask

  // Directed sequence followed by randomized operands
  initial begin
    int valid_seen;
    Reset   = 1'b1;
    Start   = 1'b1;
    use_dp  = 1'b0;
    q_force = 2'b00;
    dp_m    = '0;
    dp_r    = '0;

    repeat (2) tick();
    check_idle_outputs("reset_hold");

    Reset = 1'b0;
    tick();
    check_output("post_reset_request", Request, 1);
    check_output("post_reset_busy",    Busy,    1);
    Start = 1'b0;
    Reset = 1'b1;
    tick();
    check_idle_outputs("reset_from_load");
    Reset = 1'b0;
    tick();

    apply_stimulus("q00",  1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    apply_stimulus("q11",  1'b0, 2'b11, 8'd0, 8'd0, 1'b0);
    apply_stimulus("q10",  1'b0, 2'b10, 8'd0, 8'd0, 1'b0);
    apply_stimulus("q01",  1'b0, 2'b01, 8'd0, 8'd0, 1'b0);

    apply_stimulus("m15x23",   1'b1, 2'b00, 8'd15,   8'd23,   1'b0);
    apply_stimulus("mn15x23",  1'b1, 2'b00, 8'hF1,   8'd23,   1'b0);
    apply_stimulus("mn128sq",  1'b1, 2'b00, 8'h80,   8'h80,   1'b0);
    apply_stimulus("alt_bits", 1'b1, 2'b00, 8'h7F,   8'h55,   1'b0);

    // Abort an operation with Reset in cycle 7
    use_dp = 1'b1;
    dp_m   = 8'd15;
    dp_r   = 8'd23;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    repeat (6) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle_outputs("abort");
    valid_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (Valid || Busy) valid_seen++;
      tick();
    end
    check_output("abort_no_valid", valid_seen, 0);
    apply_stimulus("after_abort", 1'b1, 2'b00, 8'd15, 8'd23, 1'b0);

    // Start held through the whole operation
    apply_stimulus("held_start", 1'b1, 2'b00, 8'd15, 8'd23, 1'b1);
    apply_stimulus("after_held", 1'b1, 2'b00, 8'd100, 8'hC9, 1'b0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus("rand", 1'b1, 2'b00, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath (`mult`). It sits between a host and the datapath. It accepts a one-cycle start from the host, loads the operands, then runs N_LEN evaluate/shift iterations. Each iteration drives `add_s`, `sub_s` and `ashift_s` from the datapath's Booth bit-pair. At the end it asserts `Done` to the datapath and pulses `Valid` to the host.

## Interface
- `N_LEN`, 8, operand width; number of Booth iterations (legal: 2..32).
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: synchronous, active-high; returns the FSM to IDLE.
- `Start` in 1: host request; sampled only in IDLE.
- `Q_in` in 2: {Q0, Q-1} from datapath `Q_out[1:0]`.
- `Busy` out 1: high in every state except IDLE.
- `Valid` out 1: one-cycle pulse; datapath `Result` is final.
- `Request` out 1: one-cycle load strobe to datapath.
- `Done` out 1: high in FINISH; datapath freezes and presents `Result`.
- `add_s` out 1: accumulator += multiplicand.
- `sub_s` out 1: accumulator -= multiplicand.
- `ashift_s` out 1: arithmetic right shift of {A,Q,Q-1}.
- `Overrun` out 1: present only with `BOOTH_CTRL_OVR_EN` (see Configuration).

## Operation
- Moore FSM. All outputs are registered and decoded from the state register only.
- `Q_in` affects only the next-state choice out of EVAL.
- Iteration counter `cnt` is $clog2(N_LEN+1) bits wide. It is loaded with N_LEN in LOAD and decremented in SHIFT.
- States and transitions:
  - IDLE: all outputs 0. `Start`=1 → LOAD.
  - LOAD: `Request`=1, `Busy`=1, `cnt` ← N_LEN. → EVAL.
  - EVAL: no strobes. `Q_in`=2'b01 → ADD; 2'b10 → SUB; 2'b00 or 2'b11 → SHIFT.
  - ADD: `add_s`=1. → SHIFT.
  - SUB: `sub_s`=1. → SHIFT.
  - SHIFT: `ashift_s`=1, `cnt` ← `cnt`−1. If `cnt`==1 → FINISH, else → EVAL.
  - FINISH: `Done`=1, `Valid`=1. → IDLE unconditionally.
- At most one of `add_s`, `sub_s`, `ashift_s` is high in any cycle. `add_s` and `sub_s` are never high together.
- `Start` outside IDLE is ignored. This includes `Start` in FINISH; the host re-asserts it in IDLE.
- Reset in any state: on the next edge the FSM is in IDLE, every output is 0 and `cnt` is 0. An aborted operation never produces `Valid`.
- Unreachable state encodings → IDLE.

## Timing
- Reset values: `Busy`, `Valid`, `Request`, `Done`, `add_s`, `sub_s`, `ashift_s`, `Overrun` are all 0.
- Cycle numbering: edge 0 samples `Start`=1 in IDLE. The LOAD outputs are visible in cycle 1.
- Iteration k occupies 2 cycles (EVAL, SHIFT) when Q-pair is 00 or 11, and 3 cycles (EVAL, ADD/SUB, SHIFT) otherwise.
- Total latency from `Start` to `Valid` = 2 + Σ iteration lengths cycles.
  - Minimum: 2N_LEN+2 (18 for N_LEN=8).
  - Maximum: 3N_LEN+2 (26).
- `Q_in` must be stable in each EVAL cycle. The datapath updates it only on the `ashift_s` edge.
- `Busy` rises in cycle 1 and falls in the cycle after FINISH.
- A new `Start` is accepted at the earliest one cycle after `Valid`.

## Configuration
- Macro `BOOTH_CTRL_OVR_EN`.
- Defined: output `Overrun` exists.
  - Set to 1 on the edge after `Start`=1 is sampled while `Busy`=1.
  - Sticky.
  - Cleared by `Reset` or by a `Start` accepted in IDLE.
- Undefined: port and logic are absent. `Start` while busy is silently ignored.

## Test plan
- Reset: hold `Reset`=1 for 2 cycles with `Start`=1 → all outputs 0, `Busy`=0; after release, `Start` is accepted.
- `Q_in` held 2'b00, N_LEN=8, pulse `Start` → `Request` in cycle 1; 8 `ashift_s` pulses in cycles 3,5,…,17; no `add_s`/`sub_s`; `Done`/`Valid` in cycle 18.
- `Q_in` held 2'b10 → 8 `sub_s` pulses each followed by `ashift_s`; `Valid` in cycle 26; `add_s` never high.
- Connected to `mult` (N_LEN=8):
  - op1=15, op2=23 → `Result`=16'h0159 (345) when `Valid`.
  - op1=−15, op2=23 → 16'hFEA7.
  - op1=−128, op2=−128 → 16'h4000.
- `Reset` asserted in cycle 7 of an operation → cycle 8 all outputs 0, no `Valid`; the next `Start` gives a correct 15×23.
- `Start` held high for the whole operation → exactly one `Request`, one `Valid`. With `BOOTH_CTRL_OVR_EN`, `Overrun`=1 from cycle 2 until the next accepted `Start`.
